enemy_motion: RTL and testbench

Per-enemy chase controller for the boxhead game logic. Once per frame it steps the enemy one unit toward the player along the axis of greater distance. It also tracks health, stun and death, and publishes position, signed per-frame motion and facing direction. These outputs feed the enemy walk-animation step counter (which reads Obj_X_Motion/Obj_Y_Motion) and the enemy sprite renderer.

---
 rtl/enemy_motion.sv | 213 +++++++++++++++++++++
 tb/tb_enemy_motion.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_motion.sv
// enemy_motion: per-enemy chase controller for the boxhead game logic.
// Once per move frame the enemy steps one unit toward the player along the
// axis of greater distance (ties go to X). It also tracks health, a
// post-hit stun period and death, and publishes position, the signed motion
// applied at the last frame edge, facing direction and a player-touch flag.
//
// Input sampling: every input is sampled on each rising Clk edge. Hit and
// Spawn are single-cycle pulses with no handshake; a pulse that arrives in
// a state that ignores it is dropped, not queued.
module enemy_motion #(
    parameter logic [8:0] X_INIT      = 9'd40,
    parameter logic [8:0] Y_INIT      = 9'd40,
    parameter logic [8:0] STEP        = 9'd1,
    parameter logic [8:0] X_MAX       = 9'd303,
    parameter logic [8:0] Y_MAX       = 9'd223,
    parameter logic [8:0] SIZE        = 9'd16,
    parameter int         MOVE_DIV    = 2,
    parameter int         HEALTH      = 3,
    parameter int         STUN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Spawn,
    input  logic       Hit,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    output logic [8:0] Obj_X_Pos,
    output logic [8:0] Obj_Y_Pos,
    output logic [8:0] Obj_X_Motion,
    output logic [8:0] Obj_Y_Motion,
    output logic [1:0] Obj_Dir,
    output logic       Obj_Alive,
    output logic       Touch_Player,
    // Debug view of the controller state: 0 chase, 1 stun, 2 dead.
    output logic [1:0] dbg_state_o
);

    localparam int              MC_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MOVE_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_CHASE = 2'd0,
        ST_STUN  = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      x_q, x_d, y_q, y_d;
    logic [8:0]      xm_q, xm_d, ym_q, ym_d;
    logic [1:0]      dir_q, dir_d;
    logic [2:0]      health_q, health_d;
    logic [3:0]      sc_q, sc_d;
    logic [MC_W-1:0] mc_q, mc_d, mc_next;
    logic            touch_q, touch_d;
    logic            fclk_q;

    logic            fe;
    logic            move_frame;
    logic signed [9:0] dx, dy;
    logic [9:0]      adx, ady;
    logic [9:0]      x_up, y_up;
    logic [8:0]      x_inc, x_dec, y_inc, y_dec;
    logic            overlap;

    // Frame edge and move-frame qualification.
    assign fe         = frame_clk & ~fclk_q;
    assign move_frame = fe && (mc_q == MC_LAST);
    assign mc_next    = (mc_q == MC_LAST) ? '0 : mc_q + MC_W'(1);

    // Signed player-minus-enemy distances and their magnitudes.
    assign dx  = signed'({1'b0, Player_X}) - signed'({1'b0, x_q});
    assign dy  = signed'({1'b0, Player_Y}) - signed'({1'b0, y_q});
    assign adx = dx[9] ? 10'(-dx) : 10'(dx);
    assign ady = dy[9] ? 10'(-dy) : 10'(dy);

    // Candidate positions one step each way, saturated to the playfield.
    assign x_up  = {1'b0, x_q} + {1'b0, STEP};
    assign y_up  = {1'b0, y_q} + {1'b0, STEP};
    assign x_inc = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[8:0];
    assign y_inc = (y_up > {1'b0, Y_MAX}) ? Y_MAX : y_up[8:0];
    assign x_dec = (x_q >= STEP) ? (x_q - STEP) : 9'd0;
    assign y_dec = (y_q >= STEP) ? (y_q - STEP) : 9'd0;

    // Bounding boxes overlap, judged on the position before this cycle's update.
    assign overlap = (adx < {1'b0, SIZE}) && (ady < {1'b0, SIZE});

    // Next-state logic for the chase/stun/dead controller and its outputs.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xm_d     = xm_q;
        ym_d     = ym_q;
        dir_d    = dir_q;
        health_d = health_q;
        sc_d     = sc_q;
        mc_d     = mc_q;

        case (state_q)
            ST_CHASE: begin
                if (fe) begin
                    mc_d = mc_next;
                end
                if (Hit) begin
                    // A hit pre-empts any move scheduled for this cycle.
                    xm_d = 9'd0;
                    ym_d = 9'd0;
                    if (health_q > 3'd1) begin
                        health_d = health_q - 3'd1;
                        sc_d     = 4'(STUN_FRAMES);
                        state_d  = ST_STUN;
                    end else begin
                        health_d = 3'd0;
                        state_d  = ST_DEAD;
                    end
                end else if (fe) begin
                    xm_d = 9'd0;
                    ym_d = 9'd0;
                    if (move_frame) begin
                        if ((adx >= ady) && (dx != 10'sd0)) begin
                            x_d   = dx[9] ? x_dec : x_inc;
                            xm_d  = (dx[9] ? x_dec : x_inc) - x_q;
                            dir_d = dx[9] ? DIR_LEFT : DIR_RIGHT;
                        end else if (dy != 10'sd0) begin
                            y_d   = dy[9] ? y_dec : y_inc;
                            ym_d  = (dy[9] ? y_dec : y_inc) - y_q;
                            dir_d = dy[9] ? DIR_UP : DIR_DOWN;
                        end
                    end
                end
            end

            ST_STUN: begin
                // Invulnerable and motionless; only the frame edges count down.
                if (fe) begin
                    mc_d = mc_next;
                    sc_d = sc_q - 4'd1;
                    if (sc_q <= 4'd1) begin
                        sc_d    = 4'd0;
                        state_d = ST_CHASE;
                    end
                end
            end

            ST_DEAD: begin
                if (Spawn) begin
                    // Spawn takes priority over a coincident frame edge.
                    state_d  = ST_CHASE;
                    x_d      = X_INIT;
                    y_d      = Y_INIT;
                    xm_d     = 9'd0;
                    ym_d     = 9'd0;
                    health_d = 3'(HEALTH);
                    mc_d     = '0;
                end else if (fe) begin
                    mc_d = mc_next;
                end
            end

            default: begin
                state_d = ST_CHASE;
            end
        endcase
    end

    // Touch is suppressed whenever the enemy ends the cycle dead.
    assign touch_d = (state_d != ST_DEAD) && overlap;

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_CHASE;
            x_q      <= X_INIT;
            y_q      <= Y_INIT;
            xm_q     <= 9'd0;
            ym_q     <= 9'd0;
            dir_q    <= DIR_DOWN;
            health_q <= 3'(HEALTH);
            sc_q     <= 4'd0;
            mc_q     <= '0;
            touch_q  <= 1'b0;
            fclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xm_q     <= xm_d;
            ym_q     <= ym_d;
            dir_q    <= dir_d;
            health_q <= health_d;
            sc_q     <= sc_d;
            mc_q     <= mc_d;
            touch_q  <= touch_d;
            fclk_q   <= frame_clk;
        end
    end

    assign Obj_X_Pos    = x_q;
    assign Obj_Y_Pos    = y_q;
    assign Obj_X_Motion = xm_q;
    assign Obj_Y_Motion = ym_q;
    assign Obj_Dir      = dir_q;
    assign Obj_Alive    = (state_q != ST_DEAD);
    assign Touch_Player = touch_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_enemy_motion.sv
// tb_enemy_motion: directed table, hand-written corner sequences and a
// randomized phase, all checked cycle by cycle against a behavioural model
// of the chase rules.
module tb_enemy_motion;

    localparam int X_INIT      = 40;
    localparam int Y_INIT      = 40;
    localparam int STEP        = 1;
    localparam int X_MAX       = 303;
    localparam int Y_MAX       = 223;
    localparam int SIZE        = 16;
    localparam int MOVE_DIV    = 2;
    localparam int HEALTH      = 3;
    localparam int STUN_FRAMES = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       Spawn = 1'b0;
    logic       Hit = 1'b0;
    logic [8:0] Player_X = 9'd0;
    logic [8:0] Player_Y = 9'd0;
    logic [8:0] Obj_X_Pos, Obj_Y_Pos, Obj_X_Motion, Obj_Y_Motion;
    logic [1:0] Obj_Dir;
    logic       Obj_Alive, Touch_Player;
    logic [1:0] dbg_state_o;

    logic [8:0] px = 9'd0;
    logic [8:0] py = 9'd0;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 Clk = ~Clk;

    enemy_motion dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Spawn        (Spawn),
        .Hit          (Hit),
        .Player_X     (Player_X),
        .Player_Y     (Player_Y),
        .Obj_X_Pos    (Obj_X_Pos),
        .Obj_Y_Pos    (Obj_Y_Pos),
        .Obj_X_Motion (Obj_X_Motion),
        .Obj_Y_Motion (Obj_Y_Motion),
        .Obj_Dir      (Obj_Dir),
        .Obj_Alive    (Obj_Alive),
        .Touch_Player (Touch_Player),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- reference model ----------------
    int m_x, m_y, m_xm, m_ym, m_dir, m_health, m_stun, m_fes;
    bit m_touch, m_prev_fc;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_move(input int tx, input int ty);
        int dx, dy, nx, ny;
        dx = tx - m_x;
        dy = ty - m_y;
        if (dx != 0 && iabs(dx) >= iabs(dy)) begin
            nx    = clampi(m_x + ((dx > 0) ? STEP : -STEP), 0, X_MAX);
            m_xm  = nx - m_x;
            m_x   = nx;
            m_dir = (dx > 0) ? 3 : 2;
        end else if (dy != 0) begin
            ny    = clampi(m_y + ((dy > 0) ? STEP : -STEP), 0, Y_MAX);
            m_ym  = ny - m_y;
            m_y   = ny;
            m_dir = (dy > 0) ? 1 : 0;
        end
    endfunction

    function automatic void model_step(input bit fc, input bit hit, input bit spawn,
                                       input bit rst, input int tx, input int ty);
        bit fe;
        int ox, oy;
        if (rst) begin
            m_x = X_INIT; m_y = Y_INIT; m_xm = 0; m_ym = 0; m_dir = 1;
            m_health = HEALTH; m_stun = 0; m_fes = 0; m_touch = 0; m_prev_fc = 0;
            return;
        end
        fe = fc && !m_prev_fc;
        m_prev_fc = fc;
        ox = m_x;
        oy = m_y;
        if (m_health == 0) begin
            if (spawn) begin
                m_x = X_INIT; m_y = Y_INIT; m_xm = 0; m_ym = 0;
                m_health = HEALTH; m_fes = 0;
            end else if (fe) begin
                m_fes++;
            end
        end else if (m_stun > 0) begin
            if (fe) begin
                m_fes++;
                m_stun--;
            end
        end else begin
            if (fe) m_fes++;
            if (hit) begin
                m_xm = 0; m_ym = 0;
                m_health--;
                if (m_health > 0) m_stun = STUN_FRAMES;
            end else if (fe) begin
                m_xm = 0; m_ym = 0;
                if (m_fes % MOVE_DIV == 0) model_move(tx, ty);
            end
        end
        m_touch = (m_health != 0) && iabs(tx - ox) < SIZE && iabs(ty - oy) < SIZE;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("x_pos",    int'(Obj_X_Pos),    m_x);
        chk("y_pos",    int'(Obj_Y_Pos),    m_y);
        chk("x_motion", int'(Obj_X_Motion), m_xm & 'h1FF);
        chk("y_motion", int'(Obj_Y_Motion), m_ym & 'h1FF);
        chk("dir",      int'(Obj_Dir),      m_dir);
        chk("alive",    int'(Obj_Alive),    (m_health != 0) ? 1 : 0);
        chk("touch",    int'(Touch_Player), int'(m_touch));
        chk("state",    int'(dbg_state_o),  (m_health == 0) ? 2 : ((m_stun > 0) ? 1 : 0));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit fc, input bit hit, input bit spawn, input bit rst);
        @(negedge Clk);
        frame_clk = fc;
        Hit       = hit;
        Spawn     = spawn;
        Reset     = rst;
        Player_X  = px;
        Player_Y  = py;
        @(posedge Clk);
        model_step(fc, hit, spawn, rst, int'(px), int'(py));
        #1;
        check_model();
    endtask

    task automatic pulse();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         fc;
        logic [8:0] px, py;
        logic [8:0] x, y, xm, ym;
        logic [1:0] dir;
        bit         touch;
    } vec_t;

    vec_t tbl[17];

    initial begin
        bit fc_r;
        // directed table: chase along X, axis choice, tie, touch boundary
        tbl[0]  = '{1'b1, 9'd100, 9'd45, 9'd40, 9'd40, 9'd0, 9'd0,     2'd1, 1'b0};
        tbl[1]  = '{1'b0, 9'd100, 9'd45, 9'd40, 9'd40, 9'd0, 9'd0,     2'd1, 1'b0};
        tbl[2]  = '{1'b1, 9'd100, 9'd45, 9'd41, 9'd40, 9'd1, 9'd0,     2'd3, 1'b0};
        tbl[3]  = '{1'b0, 9'd100, 9'd45, 9'd41, 9'd40, 9'd1, 9'd0,     2'd3, 1'b0};
        tbl[4]  = '{1'b1, 9'd100, 9'd45, 9'd41, 9'd40, 9'd0, 9'd0,     2'd3, 1'b0};
        tbl[5]  = '{1'b0, 9'd100, 9'd45, 9'd41, 9'd40, 9'd0, 9'd0,     2'd3, 1'b0};
        tbl[6]  = '{1'b1, 9'd100, 9'd45, 9'd42, 9'd40, 9'd1, 9'd0,     2'd3, 1'b0};
        tbl[7]  = '{1'b0, 9'd100, 9'd45, 9'd42, 9'd40, 9'd1, 9'd0,     2'd3, 1'b0};
        tbl[8]  = '{1'b1, 9'd42,  9'd10, 9'd42, 9'd40, 9'd0, 9'd0,     2'd3, 1'b0};
        tbl[9]  = '{1'b0, 9'd42,  9'd10, 9'd42, 9'd40, 9'd0, 9'd0,     2'd3, 1'b0};
        tbl[10] = '{1'b1, 9'd42,  9'd10, 9'd42, 9'd39, 9'd0, 9'h1FF,   2'd0, 1'b0};
        tbl[11] = '{1'b0, 9'd42,  9'd10, 9'd42, 9'd39, 9'd0, 9'h1FF,   2'd0, 1'b0};
        tbl[12] = '{1'b1, 9'd52,  9'd49, 9'd42, 9'd39, 9'd0, 9'd0,     2'd0, 1'b1};
        tbl[13] = '{1'b0, 9'd52,  9'd49, 9'd42, 9'd39, 9'd0, 9'd0,     2'd0, 1'b1};
        tbl[14] = '{1'b1, 9'd52,  9'd49, 9'd43, 9'd39, 9'd1, 9'd0,     2'd3, 1'b1};
        tbl[15] = '{1'b0, 9'd52,  9'd49, 9'd43, 9'd39, 9'd1, 9'd0,     2'd3, 1'b1};
        tbl[16] = '{1'b0, 9'd59,  9'd39, 9'd43, 9'd39, 9'd1, 9'd0,     2'd3, 1'b0};

        // reset values
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_x",     int'(Obj_X_Pos),    40);
        chk("rst_y",     int'(Obj_Y_Pos),    40);
        chk("rst_xm",    int'(Obj_X_Motion), 0);
        chk("rst_dir",   int'(Obj_Dir),      1);
        chk("rst_alive", int'(Obj_Alive),    1);
        chk("rst_touch", int'(Touch_Player), 0);

        for (int i = 0; i < 17; i++) begin
            px = tbl[i].px;
            py = tbl[i].py;
            tick(tbl[i].fc, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_x", i),     int'(Obj_X_Pos),    int'(tbl[i].x));
            chk($sformatf("tbl%0d_y", i),     int'(Obj_Y_Pos),    int'(tbl[i].y));
            chk($sformatf("tbl%0d_xm", i),    int'(Obj_X_Motion), int'(tbl[i].xm));
            chk($sformatf("tbl%0d_ym", i),    int'(Obj_Y_Motion), int'(tbl[i].ym));
            chk($sformatf("tbl%0d_dir", i),   int'(Obj_Dir),      int'(tbl[i].dir));
            chk($sformatf("tbl%0d_touch", i), int'(Touch_Player), int'(tbl[i].touch));
        end

        // wall clamp: chase right until X saturates at X_MAX
        px = 9'd400;
        py = 9'd39;
        for (int i = 0; i < 600; i++) pulse();
        chk("wall_x", int'(Obj_X_Pos), 303);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            chk("wall_xm",  int'(Obj_X_Motion), 0);
            chk("wall_dir", int'(Obj_Dir),      3);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // spawn while alive is ignored
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("spawn_alive_x", int'(Obj_X_Pos), 303);

        // hit -> stun, second hit ignored, 8 frame edges of stun
        px = 9'd0;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hit1_state", int'(dbg_state_o),  1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hit_in_stun_state", int'(dbg_state_o), 1);
        for (int i = 0; i < STUN_FRAMES - 1; i++) pulse();
        chk("stun7_state", int'(dbg_state_o), 1);
        chk("stun7_x",     int'(Obj_X_Pos),   303);
        pulse();
        chk("stun_end_state", int'(dbg_state_o), 0);
        pulse();
        pulse();
        chk("resume_x", int'(Obj_X_Pos), 302);

        // second hit in chase -> stun, third -> dead with touch suppressed
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < STUN_FRAMES; i++) pulse();
        px = 9'd300;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dead_alive", int'(Obj_Alive),    0);
        chk("dead_touch", int'(Touch_Player), 0);
        pulse();
        pulse();
        chk("dead_frozen_x", int'(Obj_X_Pos),    302);
        chk("dead_xm",       int'(Obj_X_Motion), 0);

        // spawn coincident with a frame edge
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("spawn_x",     int'(Obj_X_Pos),    40);
        chk("spawn_y",     int'(Obj_Y_Pos),    40);
        chk("spawn_alive", int'(Obj_Alive),    1);
        chk("spawn_xm",    int'(Obj_X_Motion), 0);
        chk("spawn_ym",    int'(Obj_Y_Motion), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-stun, with a frame edge in the reset cycle
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        pulse();
        pulse();
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_stun_x",     int'(Obj_X_Pos),    40);
        chk("rst_stun_y",     int'(Obj_Y_Pos),    40);
        chk("rst_stun_dir",   int'(Obj_Dir),      1);
        chk("rst_stun_state", int'(dbg_state_o),  0);
        chk("rst_stun_touch", int'(Touch_Player), 0);
        // frame_clk held high across reset release yields one edge only
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // randomized phase against the model
        fc_r = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin
                        px = 9'(clampi(m_x + int'($urandom_range(0, 60)) - 30, 0, 511));
                        py = 9'(clampi(m_y + int'($urandom_range(0, 60)) - 30, 0, 511));
                    end
                    1: begin
                        px = 9'(clampi(m_x + int'($urandom_range(0, 20)) - 10, 0, 511));
                        py = 9'(clampi(m_y + int'(px) - m_x, 0, 511));
                    end
                    2: begin
                        px = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'd511;
                        py = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'd511;
                    end
                    default: begin
                        px = 9'($urandom_range(0, 511));
                        py = 9'($urandom_range(0, 511));
                    end
                endcase
            end
            if ($urandom_range(0, 3) == 0) fc_r = ~fc_r;
            tick(fc_r,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 999) == 0);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
